sh4a_mul_ctrl: RTL and testbench
================================

# sh4a_mul_ctrl

Multi-cycle multiply sequencer and MAC register owner for the SH4A core. It receives multiply-class operations from issue after decode (`mul.l`, `muls.w`, `mulu.w`, `dmuls.l`, `dmulu.l`) plus `clrmac` and `lds` to MACH/MACL. It sequences one shared 17x17 signed multiplier over 16-bit partial products and holds MACH/MACL. `busy` stalls issue of any MAC reader or new multiply.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  operation offered
- issue_ready  out  1  high only in IDLE; accept = issue_valid & issue_ready
- issue_op  in  3  0 MULL, 1 MULSW, 2 MULUW, 3 DMULSL, 4 DMULUL, 5 CLRMAC, 6 LDS_MACL, 7 LDS_MACH
- issue_src1  in  32  Rn value (LDS data source)
- issue_src2  in  32  Rm value
- abort  in  1  pipeline flush: kill in-flight op, no MAC update
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse in WB state
- macl  out  32  MACL register
- mach  out  32  MACH register

## Operation
- Operands are latched on accept. Word ops use src[15:0] only: sign-extended to 17 bits for MULSW, zero-extended for MULUW.
- CLRMAC, LDS_MACL and LDS_MACH complete on the accept edge. CLRMAC zeroes both MAC registers; LDS writes src1 to the named register. The block stays in IDLE, `busy` stays low, and there is no `done` pulse.
- States: IDLE, MUL, CORR, WB.
- IDLE: on accepting a multiply, load the partial-product counter, clear the 64-bit accumulator, and go to MUL.
- MUL:
  - One unsigned 16x16 partial product per cycle, shifted and added into the accumulator. Word ops use a single signed 17x17 product instead.
  - Partial-product order: LL, LH, HL, HH.
  - Count P: MULSW/MULUW 1, MULL 3 (HH skipped), DMUL 4.
  - After the P-th cycle, go to CORR if DMULSL, else to WB.
- CORR (DMULSL only): acc[63:32] -= (a[31] ? b : 0) + (b[31] ? a : 0), modulo 2^32. Then go to WB.
- WB: pulse `done` and update MAC on the edge leaving WB, then return to IDLE.
  - MULL, MULSW, MULUW: MACL <= acc[31:0]; MACH unchanged.
  - DMUL: MACH <= acc[63:32], MACL <= acc[31:0].
- All arithmetic is modulo 2^64; the accumulator never saturates.
- Abort:
  - In MUL, CORR or WB, `abort` forces IDLE on the next edge.
  - MAC registers are not written, even when abort arrives in WB.
  - `done` is suppressed in the cycle `abort` is high.
  - In IDLE, `abort` has no effect, and an accept in the same cycle still completes.
- `rst` overrides everything, including an accept in the same cycle. It returns the block to IDLE with macl = mach = 0.

## Timing
- Reset values: issue_ready 1, busy 0, done 0, macl 0, mach 0.
- Latency, counted in edges from the accept edge to the MAC update edge:
  - MULSW/MULUW: 2
  - MULL: 4
  - DMULUL: 5
  - DMULSL: 6
  - CLRMAC/LDS: 0 (update on the accept edge)
- `done` is high in the cycle before the MAC update edge.
- `issue_ready` returns high in the cycle after the MAC update edge, so back-to-back throughput is latency + 1 cycles per multiply.
- After an abort, `issue_ready` is high in the cycle following the abort edge.
- issue_valid may be held with changing operands while not ready; only values at the accept edge matter.
- MAC outputs are registers with no combinational path from the inputs.

## Test plan
- MULUW, src1 = 0x0001FFFF, src2 = 0x0000FFFF, MACH preset to 0xAAAA5555 via LDS -> MACL = 0xFFFE0001 two edges after accept; MACH still 0xAAAA5555; done pulse seen once.
- MULSW, src1 = 0x0000FFFF, src2 = 0x00000002 -> MACL = 0xFFFFFFFE.
- DMULSL, 0xFFFFFFFF x 0x00000002 -> MACH = 0xFFFFFFFF, MACL = 0xFFFFFFFE six edges after accept. Then DMULUL, 0xFFFFFFFF x 0xFFFFFFFF -> MACH = 0xFFFFFFFE, MACL = 0x00000001 after five edges.
- MULL, 0x12345678 x 0x00000010 -> MACL = 0x23456780 after four edges. Repeat with abort in the second MUL cycle -> MACL unchanged, no done, issue_ready high the next cycle.
- Back-to-back: a CLRMAC accepted with ready high clears both registers the same edge. A following DMULUL, 0x00010000 x 0x00010000, gives MACH = 0x00000001, MACL = 0. Check busy is high for exactly 5 cycles.
- rst asserted during DMULUL CORR/MUL -> next cycle busy 0, macl = mach = 0, issue_ready 1. A multiply issued afterwards completes normally.

Source files
------------

// File: rtl/sh4a_mul_ctrl.sv
// Multiply sequencer and MACH/MACL owner: one shared 17x17 signed multiplier is
// stepped over 16-bit partial products, with a signed-high correction for dmuls.l.
module sh4a_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [2:0]  issue_op,
  input  logic [31:0] issue_src1,
  input  logic [31:0] issue_src2,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] macl,
  output logic [31:0] mach
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CORR = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULL     = 3'd0;
  localparam logic [2:0] OP_MULSW    = 3'd1;
  localparam logic [2:0] OP_MULUW    = 3'd2;
  localparam logic [2:0] OP_DMULSL   = 3'd3;
  localparam logic [2:0] OP_DMULUL   = 3'd4;
  localparam logic [2:0] OP_CLRMAC   = 3'd5;
  localparam logic [2:0] OP_LDS_MACL = 3'd6;
  localparam logic [2:0] OP_LDS_MACH = 3'd7;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [63:0] acc_r;
  logic [1:0]  idx_r;
  logic [1:0]  last_idx_r;
  logic        busy_r;
  logic        wb_r;
  logic [31:0] macl_r;
  logic [31:0] mach_r;

  logic               accept_s;
  logic               word_op_s;
  logic signed [16:0] mul_x_s;
  logic signed [16:0] mul_y_s;
  logic signed [33:0] prod_s;
  logic [63:0]        prod64_s;
  logic [63:0]        pp_s;
  logic [31:0]        corr_s;
  logic [1:0]         first_last_idx_s;

  assign accept_s    = issue_valid & ~busy_r;
  assign word_op_s   = (op_r == OP_MULSW) || (op_r == OP_MULUW);
  assign issue_ready = ~busy_r;
  assign busy        = busy_r;
  assign done        = wb_r & ~abort;
  assign macl        = macl_r;
  assign mach        = mach_r;

  // Operand selection for the shared multiplier: word ops use one signed product,
  // long ops walk LL, LH, HL, HH as zero-extended 16-bit halves.
  always_comb begin
    mul_x_s = 17'sd0;
    mul_y_s = 17'sd0;
    if (word_op_s) begin
      if (op_r == OP_MULSW) begin
        mul_x_s = {a_r[15], a_r[15:0]};
        mul_y_s = {b_r[15], b_r[15:0]};
      end else begin
        mul_x_s = {1'b0, a_r[15:0]};
        mul_y_s = {1'b0, b_r[15:0]};
      end
    end else begin
      case (idx_r)
        2'd0: begin mul_x_s = {1'b0, a_r[15:0]};  mul_y_s = {1'b0, b_r[15:0]};  end
        2'd1: begin mul_x_s = {1'b0, a_r[15:0]};  mul_y_s = {1'b0, b_r[31:16]}; end
        2'd2: begin mul_x_s = {1'b0, a_r[31:16]}; mul_y_s = {1'b0, b_r[15:0]};  end
        2'd3: begin mul_x_s = {1'b0, a_r[31:16]}; mul_y_s = {1'b0, b_r[31:16]}; end
        default: begin mul_x_s = 17'sd0; mul_y_s = 17'sd0; end
      endcase
    end
  end

  assign prod_s   = {{17{mul_x_s[16]}}, mul_x_s} * {{17{mul_y_s[16]}}, mul_y_s};
  assign prod64_s = {{30{prod_s[33]}}, prod_s};

  // Align the partial product to its weight in the 64-bit accumulator.
  always_comb begin
    pp_s = 64'd0;
    case (idx_r)
      2'd0:    pp_s = prod64_s;
      2'd1:    pp_s = prod64_s << 16;
      2'd2:    pp_s = prod64_s << 16;
      2'd3:    pp_s = prod64_s << 32;
      default: pp_s = 64'd0;
    endcase
  end

  // Unsigned-to-signed high-word fixup for dmuls.l.
  assign corr_s = (a_r[31] ? b_r : 32'd0) + (b_r[31] ? a_r : 32'd0);

  // Number of partial products minus one for the op being accepted.
  always_comb begin
    first_last_idx_s = 2'd0;
    case (issue_op)
      OP_MULL:   first_last_idx_s = 2'd2;
      OP_DMULSL: first_last_idx_s = 2'd3;
      OP_DMULUL: first_last_idx_s = 2'd3;
      default:   first_last_idx_s = 2'd0;
    endcase
  end

  // Sequencer FSM, accumulator and MAC register updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      op_r       <= 3'd0;
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      acc_r      <= 64'd0;
      idx_r      <= 2'd0;
      last_idx_r <= 2'd0;
      busy_r     <= 1'b0;
      wb_r       <= 1'b0;
      macl_r     <= 32'd0;
      mach_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (issue_op)
              OP_CLRMAC: begin
                macl_r <= 32'd0;
                mach_r <= 32'd0;
              end
              OP_LDS_MACL: macl_r <= issue_src1;
              OP_LDS_MACH: mach_r <= issue_src1;
              default: begin
                op_r       <= issue_op;
                a_r        <= issue_src1;
                b_r        <= issue_src2;
                acc_r      <= 64'd0;
                idx_r      <= 2'd0;
                last_idx_r <= first_last_idx_s;
                busy_r     <= 1'b1;
                state_r    <= ST_MUL;
              end
            endcase
          end
        end
        ST_MUL: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_r <= acc_r + pp_s;
            idx_r <= idx_r + 2'd1;
            if (idx_r == last_idx_r) begin
              if (op_r == OP_DMULSL) begin
                state_r <= ST_CORR;
              end else begin
                state_r <= ST_WB;
                wb_r    <= 1'b1;
              end
            end
          end
        end
        ST_CORR: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            acc_r[63:32] <= acc_r[63:32] - corr_s;
            state_r      <= ST_WB;
            wb_r         <= 1'b1;
          end
        end
        ST_WB: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          wb_r    <= 1'b0;
          if (!abort) begin
            macl_r <= acc_r[31:0];
            if ((op_r == OP_DMULSL) || (op_r == OP_DMULUL)) begin
              mach_r <= acc_r[63:32];
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          wb_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sh4a_mul_ctrl.sv
// Scoreboard bench for sh4a_mul_ctrl: the driver pushes expected MAC values and
// latency on accept; a monitor pops and checks them whenever done pulses.
module tb_sh4a_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_op = 3'd0;
  logic [31:0] issue_src1 = 32'd0;
  logic [31:0] issue_src2 = 32'd0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] macl;
  logic [31:0] mach;

  sh4a_mul_ctrl dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .abort(abort), .busy(busy), .done(done), .macl(macl), .mach(mach)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] macl;
    logic [31:0] mach;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   last_acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a done pulse means the MAC update lands on the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          @(posedge clk);
          #1;
          chk("macl", {32'd0, macl}, {32'd0, e.macl});
          chk("mach", {32'd0, mach}, {32'd0, e.mach});
          chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2);
    int n;
    n = 0;
    @(negedge clk);
    while (issue_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("ready_timeout", 64'd1, 64'd0);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_src1  = s1;
    issue_src2  = s2;
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    issue_valid = 1'b0;
    issue_src1  = 32'hDEAD_BEEF;
    issue_src2  = 32'hDEAD_BEEF;
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] h, input int lat);
    exp_t e;
    e.macl = l;
    e.mach = h;
    e.lat = lat;
    e.acc_cyc = last_acc_cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (issue_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int d0;
    int bcnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, issue_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_macl", {32'd0, macl}, 64'd0);
    chk("rst_mach", {32'd0, mach}, 64'd0);

    issue(3'd7, 32'hAAAA_5555, 32'd0);
    chk("lds_mach", {32'd0, mach}, 64'h0000_0000_AAAA_5555);
    chk("lds_busy", {63'd0, busy}, 64'd0);
    issue(3'd6, 32'h1357_9BDF, 32'd0);
    chk("lds_macl", {32'd0, macl}, 64'h0000_0000_1357_9BDF);

    d0 = done_cnt;
    issue(3'd2, 32'h0001_FFFF, 32'h0000_FFFF);
    push(32'hFFFE_0001, 32'hAAAA_5555, 2);
    wait_idle();
    chk("muluw_done_once", 64'(done_cnt - d0), 64'd1);

    issue(3'd1, 32'h0000_FFFF, 32'h0000_0002);
    push(32'hFFFF_FFFE, 32'hAAAA_5555, 2);
    wait_idle();

    issue(3'd3, 32'hFFFF_FFFF, 32'h0000_0002);
    push(32'hFFFF_FFFE, 32'hFFFF_FFFF, 6);
    wait_idle();

    issue(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(32'h0000_0001, 32'hFFFF_FFFE, 5);
    wait_idle();

    issue(3'd0, 32'h1234_5678, 32'h0000_0010);
    push(32'h2345_6780, 32'hFFFF_FFFE, 4);
    wait_idle();

    // Abort in the second MUL cycle
    d0 = done_cnt;
    issue(3'd0, 32'h0000_0003, 32'h0000_0005);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_ready", {63'd0, issue_ready}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_macl", {32'd0, macl}, 64'h0000_0000_2345_6780);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    issue(3'd5, 32'd0, 32'd0);
    chk("clr_macl", {32'd0, macl}, 64'd0);
    chk("clr_mach", {32'd0, mach}, 64'd0);
    issue(3'd4, 32'h0001_0000, 32'h0001_0000);
    push(32'h0000_0000, 32'h0000_0001, 5);
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
    end
    chk("busy_cycles", 64'(bcnt), 64'd5);

    // Reset in the middle of a DMULUL
    issue(3'd4, 32'hFFFF_FFFF, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_ready", {63'd0, issue_ready}, 64'd1);
    chk("mid_rst_macl", {32'd0, macl}, 64'd0);
    chk("mid_rst_mach", {32'd0, mach}, 64'd0);

    issue(3'd2, 32'h0000_0003, 32'h0000_0005);
    push(32'h0000_000F, 32'h0000_0000, 2);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
